// File: rtl/ping_pong_pkg.sv
// Sizing and shared types for the west-edge ping-pong operand buffer.
// All widths derive from element width, chunking and core count.
package ping_pong_pkg;

    localparam int WIDTH             = 16;
    localparam int PP_CHUNK_SIZE     = 4;
    localparam int W_NUM_CORES_A     = 2;
    localparam int W_TOTAL_MODULES   = 2;
    localparam int W_COL_X           = 4;
    localparam int TOTAL_INPUT_W_W   = 2;
    localparam int COL_SIZE_MAT_C_PP = 2;

    localparam int W_MODULE_WIDTH = WIDTH * PP_CHUNK_SIZE * W_NUM_CORES_A;
    localparam int W_IN_WIDTH     = W_MODULE_WIDTH * W_TOTAL_MODULES;
    localparam int W_TOTAL_DEPTH  = W_COL_X * TOTAL_INPUT_W_W;
    localparam int W_WR_ROWS      = W_TOTAL_DEPTH / W_TOTAL_MODULES;

    localparam int ADDR_WIDTH_W = (W_TOTAL_DEPTH > 1) ? $clog2(W_TOTAL_DEPTH) : 1;
    localparam int WR_ROW_W     = (W_WR_ROWS > 1) ? $clog2(W_WR_ROWS) : 1;
    localparam int PASS_W       = (COL_SIZE_MAT_C_PP > 1) ? $clog2(COL_SIZE_MAT_C_PP) : 1;

    typedef enum logic {RD_IDLE, RD_STREAM} pp_rd_state_t;

endpackage

// File: rtl/west_ping_pong_buffer_if.sv
// Upstream beat handshake and west-edge word handshake of the buffer.
// The slave modport is the buffer side, master is the environment side.
interface west_ping_pong_buffer_if;
    import ping_pong_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [W_IN_WIDTH-1:0]     in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [W_MODULE_WIDTH-1:0] out_data;
    logic                      out_last;
    logic [1:0]                bank_full;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, bank_full
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, bank_full
    );

endinterface

// File: rtl/pp_bank_ram.sv
// One bank: wide row writes of a full input beat, narrow word reads.
// Read data is registered and holds whenever no read is issued.
module pp_bank_ram
    import ping_pong_pkg::*;
(
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [WR_ROW_W-1:0]       i_wr_row,
    input  logic [W_IN_WIDTH-1:0]     i_wr_data,
    input  logic                      i_re,
    input  logic [ADDR_WIDTH_W-1:0]   i_rd_addr,
    output logic [W_MODULE_WIDTH-1:0] o_rd_data
);

    logic [W_MODULE_WIDTH-1:0] r_mem [W_TOTAL_DEPTH];
    logic [W_MODULE_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int m = 0; m < W_TOTAL_MODULES; m++) begin
                r_mem[ADDR_WIDTH_W'(int'(i_wr_row) * W_TOTAL_MODULES + m)]
                    <= i_wr_data[m*W_MODULE_WIDTH +: W_MODULE_WIDTH];
            end
        end
        if (i_re) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/west_ping_pong_buffer.sv
// Ping-pong west-edge store: one bank fills while the other is replayed
// NUM_REUSE times as a stream of MODULE_WIDTH words.
module west_ping_pong_buffer
    import ping_pong_pkg::*;
(
    input logic                     clk,
    input logic                     rst,
    west_ping_pong_buffer_if.slave  bus
);

    if ((W_TOTAL_DEPTH % W_TOTAL_MODULES) != 0) begin : g_depth_chk
        $error("DEPTH must be a multiple of TOTAL_MODULES");
    end

    localparam logic [ADDR_WIDTH_W-1:0] LAST_ADDR =
        ADDR_WIDTH_W'(W_TOTAL_DEPTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(COL_SIZE_MAT_C_PP - 1);
    localparam logic [WR_ROW_W-1:0] LAST_ROW = WR_ROW_W'(W_WR_ROWS - 1);

    logic [1:0]              r_bank_full;
    logic                    r_wr_sel;
    logic                    r_rd_sel;
    logic                    r_iss_sel;
    logic [WR_ROW_W-1:0]     r_wr_row;
    logic [ADDR_WIDTH_W-1:0] r_rd_addr;
    logic [PASS_W-1:0]       r_pass;
    pp_rd_state_t            r_state;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_out_sel;

    pp_rd_state_t            w_state_nx;
    logic [ADDR_WIDTH_W-1:0] w_addr_nx;
    logic [PASS_W-1:0]       w_pass_nx;
    logic                    w_iss_sel_nx;

    logic                      w_in_acc;
    logic                      w_wr_done;
    logic                      w_out_acc;
    logic                      w_rd_done;
    logic                      w_rd_en;
    logic                      w_iss_last;
    logic [1:0]                w_set;
    logic [1:0]                w_clr;
    logic [1:0]                w_we;
    logic [1:0]                w_re;
    logic [W_MODULE_WIDTH-1:0] w_rd_data [2];

    assign bus.in_ready = !r_bank_full[r_wr_sel];

    assign w_in_acc  = bus.in_valid && bus.in_ready;
    assign w_wr_done = w_in_acc && (r_wr_row == LAST_ROW);
    assign w_out_acc = r_out_valid && bus.out_ready;
    assign w_rd_done = w_out_acc && r_out_last;

    assign w_set = w_wr_done ? (2'b01 << r_wr_sel) : 2'b00;
    assign w_clr = w_rd_done ? (2'b01 << r_rd_sel) : 2'b00;

    assign w_rd_en    = (r_state == RD_STREAM) && (!r_out_valid || bus.out_ready);
    assign w_iss_last = (r_rd_addr == LAST_ADDR) && (r_pass == LAST_PASS);

    assign w_we[0] = w_in_acc && !r_wr_sel;
    assign w_we[1] = w_in_acc &&  r_wr_sel;
    assign w_re[0] = w_rd_en  && !r_iss_sel;
    assign w_re[1] = w_rd_en  &&  r_iss_sel;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank_ram u_ram (
            .clk       (clk),
            .i_we      (w_we[b]),
            .i_wr_row  (r_wr_row),
            .i_wr_data (bus.in_data),
            .i_re      (w_re[b]),
            .i_rd_addr (r_rd_addr),
            .o_rd_data (w_rd_data[b])
        );
    end

    // Issue runs one word ahead of drain, so it may move to the next bank
    // while the previous bank's final word still waits in the output stage.
    always_comb begin
        w_state_nx   = r_state;
        w_addr_nx    = r_rd_addr;
        w_pass_nx    = r_pass;
        w_iss_sel_nx = r_iss_sel;
        unique case (r_state)
            RD_IDLE: begin
                if (r_bank_full[r_iss_sel]) begin
                    w_state_nx = RD_STREAM;
                    w_addr_nx  = '0;
                    w_pass_nx  = '0;
                end
            end
            RD_STREAM: begin
                if (w_rd_en) begin
                    if (w_iss_last) begin
                        w_iss_sel_nx = !r_iss_sel;
                        w_addr_nx    = '0;
                        w_pass_nx    = '0;
                        if (!r_bank_full[!r_iss_sel]) begin
                            w_state_nx = RD_IDLE;
                        end
                    end else if (r_rd_addr == LAST_ADDR) begin
                        w_addr_nx = '0;
                        w_pass_nx = r_pass + 1'b1;
                    end else begin
                        w_addr_nx = r_rd_addr + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RD_IDLE;
            r_rd_addr <= '0;
            r_pass    <= '0;
            r_iss_sel <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_rd_addr <= w_addr_nx;
            r_pass    <= w_pass_nx;
            r_iss_sel <= w_iss_sel_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_full <= 2'b00;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_wr_row    <= '0;
        end else begin
            r_bank_full <= (r_bank_full | w_set) & ~w_clr;
            if (w_in_acc) begin
                r_wr_row <= w_wr_done ? '0 : r_wr_row + 1'b1;
            end
            if (w_wr_done) begin
                r_wr_sel <= !r_wr_sel;
            end
            if (w_rd_done) begin
                r_rd_sel <= !r_rd_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sel   <= 1'b0;
        end else if (!r_out_valid || bus.out_ready) begin
            r_out_valid <= w_rd_en;
            r_out_last  <= w_rd_en && w_iss_last;
            if (w_rd_en) begin
                r_out_sel <= r_iss_sel;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = r_out_valid ? w_rd_data[r_out_sel] : '0;
    assign bus.bank_full = r_bank_full;

    a_no_same_bank_set_clr: assert property (
        @(posedge clk) disable iff (rst)
        !(w_wr_done && w_rd_done && (r_wr_sel == r_rd_sel))
    );

endmodule
